register_bank_param: RTL and testbench

// - Parametrised multi-port MIPS register file; next generation of the datapath register bank.
// - Provides: NUM_READ combinational read ports, write-through bypass, hardwired $zero,
//   a memory-mapped input register and a registered display output.
// - Adds a handshaked dump engine that streams every register to the debug/display path.

---
 rtl/regbank_pkg.sv | 26 ++
 rtl/regbank_dump_fsm.sv | 70 +++++++
 rtl/register_bank_param.sv | 91 +++++++++
 tb/tb_register_bank_param.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types and constants for the parametrised MIPS register bank.
package regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dump_state_t;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int ZERO_REG       = 0;

  function automatic int clog2(input int unsigned value);
    int          bits;
    int unsigned v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/regbank_dump_fsm.sv
// Dump engine: walks every register index once with a valid/ready handshake.
module regbank_dump_fsm
  import regbank_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic          o_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  dump_state_t   r_state;
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic          r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= RUN;
            r_valid <= 1'b1;
            r_addr  <= '0;
          end
        end
        RUN: begin
          if (i_ready) begin
            if (r_addr == LAST_IDX) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_addr <= r_addr + AW'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_addr  <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_addr  <= '0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_done  = r_done;

endmodule

// File: rtl/register_bank_param.sv
// Multi-port MIPS register file with write-through bypass, hardwired $zero,
// memory-mapped input register, registered display output and dump engine.
module register_bank_param
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NUM_READ = 2,
  parameter int IN_W     = 6,
  parameter int IN_REG   = 30,
  parameter int OUT_REG  = 31
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [NUM_READ*clog2(DEPTH)-1:0]      read_addr,
  output logic [NUM_READ*DATA_W-1:0]            read_data,
  input  logic                                  RegWrite,
  input  logic [clog2(DEPTH)-1:0]               writeRegister,
  input  logic [DATA_W-1:0]                     writeData,
  input  logic [IN_W-1:0]                       user_in,
  output logic [DATA_W-1:0]                     toDisplay,
  output logic                                  display_update,
  input  logic                                  dump_start,
  input  logic                                  dump_ready,
  output logic                                  dump_valid,
  output logic [clog2(DEPTH)-1:0]               dump_addr,
  output logic [DATA_W-1:0]                     dump_data,
  output logic                                  dump_done
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);
  localparam logic [AW-1:0] IN_IDX   = AW'(IN_REG);
  localparam logic [AW-1:0] OUT_IDX  = AW'(OUT_REG);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_to_display;
  logic              r_display_update;
  logic              w_wr_en;
  logic [AW-1:0]     w_dump_addr;

  assign w_wr_en = RegWrite && (writeRegister != ZERO_IDX) && (writeRegister != IN_IDX);

  // IN_REG never bypasses: its next value comes from user_in, not writeData.
  function automatic logic [DATA_W-1:0] f_read(input logic [AW-1:0] addr);
    if (addr == ZERO_IDX) return '0;
    if (RegWrite && (writeRegister == addr) && (addr != IN_IDX)) return writeData;
    return r_regs[addr];
  endfunction

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_data;
    assign w_addr = read_addr[gi*AW +: AW];
    assign w_data = f_read(w_addr);
    assign read_data[gi*DATA_W +: DATA_W] = w_data;
  end

  // Display samples OUT_REG before this edge's write, giving one cycle of lag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_regs           <= '{default: '0};
      r_to_display     <= '0;
      r_display_update <= 1'b0;
    end else begin
      if (w_wr_en) r_regs[writeRegister] <= writeData;
      r_regs[IN_IDX]   <= DATA_W'(user_in);
      r_to_display     <= r_regs[OUT_IDX];
      r_display_update <= (r_regs[OUT_IDX] != r_to_display);
    end
  end

  regbank_dump_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dump_fsm (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_start (dump_start),
    .i_ready (dump_ready),
    .o_valid (dump_valid),
    .o_addr  (w_dump_addr),
    .o_done  (dump_done)
  );

  assign dump_addr      = w_dump_addr;
  assign dump_data      = f_read(w_dump_addr);
  assign toDisplay      = r_to_display;
  assign display_update = r_display_update;

endmodule

// File: tb/tb_register_bank_param.sv
// Scoreboard bench for register_bank_param: reads, IN_REG, display and dump engine.
module tb_register_bank_param;

  logic        clock;
  logic        reset_n;
  logic [9:0]  read_addr;
  logic [63:0] read_data;
  logic        RegWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [5:0]  user_in;
  logic [31:0] toDisplay;
  logic        display_update;
  logic        dump_start;
  logic        dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;

  register_bank_param #(
    .DATA_W   (32),
    .DEPTH    (32),
    .NUM_READ (2),
    .IN_W     (6),
    .IN_REG   (30),
    .OUT_REG  (31)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .RegWrite       (RegWrite),
    .writeRegister  (writeRegister),
    .writeData      (writeData),
    .user_in        (user_in),
    .toDisplay      (toDisplay),
    .display_update (display_update),
    .dump_start     (dump_start),
    .dump_ready     (dump_ready),
    .dump_valid     (dump_valid),
    .dump_addr      (dump_addr),
    .dump_data      (dump_data),
    .dump_done      (dump_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          port;
    logic [4:0]  addr;
    logic [31:0] exp;
    string       name;
  } rd_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  rd_t   rd_q[$];
  beat_t beat_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    exp_done = 0;
  int    done_cnt = 0;
  int    beat_cnt = 0;
  logic  hold_pend = 1'b0;
  logic [4:0] hold_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_expect(input int port, input logic [4:0] addr, input logic [31:0] exp,
                           input string name);
    read_addr[port*5 +: 5] = addr;
    rd_q.push_back('{port, addr, exp, name});
  endtask

  function automatic logic [31:0] preload_val(input int n, input int in_val);
    if (n == 30) return 32'(in_val);
    return 32'(n * 3);
  endfunction

  // Monitor: consumes read expectations and dump beats at the falling edge.
  always @(negedge clock) begin
    rd_t   e;
    beat_t b;
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk(e.name, read_data[e.port*32 +: 32], e.exp);
    end
    if (reset_n) begin
      if (hold_pend && dump_valid) chk("dump_hold_addr", 32'(dump_addr), 32'(hold_addr));
      hold_pend = 1'b0;
      if (dump_valid && dump_ready) begin
        beat_cnt++;
        if (beat_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dump_extra_beat: got beat at addr %0d, expected no beat", dump_addr);
        end else begin
          b = beat_q.pop_front();
          chk("dump_addr", 32'(dump_addr), 32'(b.addr));
          chk("dump_data", dump_data, b.data);
        end
      end else if (dump_valid) begin
        hold_pend = 1'b1;
        hold_addr = dump_addr;
      end
      if (dump_done) begin
        done_cnt++;
        n_vec++;
        if (exp_done == 0) begin
          n_err++;
          $display("FAIL dump_done_extra: got dump_done=1, expected 0");
        end else begin
          exp_done--;
        end
      end
    end
  end

  initial begin
    reset_n       = 1'b1;
    read_addr     = {5'd31, 5'd5};
    RegWrite      = 1'b0;
    writeRegister = '0;
    writeData     = '0;
    user_in       = '0;
    dump_start    = 1'b0;
    dump_ready    = 1'b0;

    // Asynchronous reset, checked with no clock edge in between.
    #13;
    reset_n = 1'b0;
    #1;
    chk("rst_read_p0", read_data[31:0], 32'h0);
    chk("rst_read_p1", read_data[63:32], 32'h0);
    chk("rst_toDisplay", toDisplay, 32'h0);
    chk("rst_display_update", 32'(display_update), 32'h0);
    chk("rst_dump_valid", 32'(dump_valid), 32'h0);
    chk("rst_dump_addr", 32'(dump_addr), 32'h0);
    chk("rst_dump_done", 32'(dump_done), 32'h0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();

    // Write/read with bypass.
    RegWrite = 1'b1; writeRegister = 5'd5; writeData = 32'hDEADBEEF;
    rd_expect(0, 5'd5, 32'hDEADBEEF, "bypass_r5_p0");
    rd_expect(1, 5'd5, 32'hDEADBEEF, "bypass_r5_p1");
    cyc();
    RegWrite = 1'b1; writeRegister = 5'd0; writeData = 32'hFFFFFFFF;
    rd_expect(0, 5'd5, 32'hDEADBEEF, "stored_r5");
    rd_expect(1, 5'd0, 32'h0, "r0_no_bypass");
    cyc();
    RegWrite = 1'b0;
    rd_expect(1, 5'd0, 32'h0, "r0_after_write");
    cyc();

    // IN_REG: user_in wins, no bypass from writeData.
    user_in = 6'h2A; RegWrite = 1'b1; writeRegister = 5'd30; writeData = 32'h1234;
    rd_expect(1, 5'd30, 32'h0, "in_reg_no_bypass");
    cyc();
    RegWrite = 1'b0;
    rd_expect(1, 5'd30, 32'h2A, "in_reg_user_wins");
    cyc();

    // Display path: one cycle of lag behind OUT_REG.
    RegWrite = 1'b1; writeRegister = 5'd31; writeData = 32'h55;
    cyc();
    RegWrite = 1'b0;
    chk("disp_edge_k", toDisplay, 32'h0);
    chk("disp_upd_edge_k", 32'(display_update), 32'h0);
    cyc();
    chk("disp_edge_k1", toDisplay, 32'h55);
    chk("disp_upd_edge_k1", 32'(display_update), 32'h1);
    cyc();
    chk("disp_upd_edge_k2", 32'(display_update), 32'h0);
    RegWrite = 1'b1; writeRegister = 5'd31; writeData = 32'h55;
    cyc();
    RegWrite = 1'b0;
    chk("disp_rewrite_upd_m", 32'(display_update), 32'h0);
    cyc();
    chk("disp_rewrite_upd_m1", 32'(display_update), 32'h0);
    chk("disp_rewrite_val", toDisplay, 32'h55);

    // Preload rN = N*3 (r30 keeps user_in).
    for (int n = 1; n < 32; n++) begin
      RegWrite = 1'b1; writeRegister = 5'(n); writeData = 32'(n * 3);
      cyc();
    end
    RegWrite = 1'b0;
    cyc();

    // Dump with ready toggling and an ignored second start.
    for (int n = 0; n < 32; n++) beat_q.push_back('{5'(n), preload_val(n, 42)});
    exp_done = 1; done_cnt = 0;
    dump_start = 1'b1; dump_ready = 1'b1;
    cyc();
    for (int i = 0; i < 300; i++) begin
      if (done_cnt > 0) break;
      dump_start = (i == 6);
      dump_ready = (i % 2 == 0);
      cyc();
    end
    dump_start = 1'b0;
    dump_ready = 1'b0;
    chk("dump1_done_seen", 32'(done_cnt), 32'h1);
    cyc();
    cyc();
    chk("dump1_idle_valid", 32'(dump_valid), 32'h0);
    chk("dump1_beats_left", 32'(beat_q.size()), 32'h0);

    // Reset in the middle of a dump.
    for (int n = 0; n < 10; n++) beat_q.push_back('{5'(n), preload_val(n, 42)});
    exp_done = 0; beat_cnt = 0;
    dump_start = 1'b1; dump_ready = 1'b1;
    cyc();
    dump_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (beat_cnt >= 10) break;
      cyc();
    end
    chk("dump2_beats_before_rst", 32'(beat_cnt), 32'd10);
    reset_n = 1'b0;
    read_addr[4:0] = 5'd5;
    #1;
    chk("dump2_rst_valid", 32'(dump_valid), 32'h0);
    chk("dump2_rst_addr", 32'(dump_addr), 32'h0);
    chk("dump2_rst_done", 32'(dump_done), 32'h0);
    chk("dump2_rst_r5", read_data[31:0], 32'h0);
    cyc();
    cyc();
    reset_n = 1'b1;
    dump_ready = 1'b0;
    repeat (5) cyc();
    chk("dump2_idle_valid", 32'(dump_valid), 32'h0);
    chk("dump2_beats_left", 32'(beat_q.size()), 32'h0);

    // Restart after reset: registers cleared, r30 reloaded from user_in.
    for (int n = 0; n < 32; n++) beat_q.push_back('{5'(n), (n == 30) ? 32'h2A : 32'h0});
    exp_done = 1; done_cnt = 0;
    dump_start = 1'b1; dump_ready = 1'b1;
    cyc();
    dump_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt > 0) break;
      cyc();
    end
    dump_ready = 1'b0;
    chk("dump3_done_seen", 32'(done_cnt), 32'h1);
    cyc();
    cyc();
    chk("dump3_beats_left", 32'(beat_q.size()), 32'h0);
    chk("dump3_idle_valid", 32'(dump_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
